aud_sample_fifo: RTL and testbench
==================================

// Module: aud_sample_fifo
//
// PURPOSE
// Stereo sample buffer feeding the I2S transmitter. Accepts 16-bit left/right
// pairs from the synth/mixer on a valid/ready handshake and stores them in a
// DEPTH-entry FIFO. On each single-cycle request pulse from the I2S transmitter
// it pops one pair and presents it as a packed 32-bit word held for a full
// frame. A PRIME/RUN state machine masks start-up fill and recovers from underrun.
//
// PARAMETERS
// DEPTH      8   FIFO entries; power of two, >= 4
// PRIME_LVL  4   entries required before leaving PRIME; 1..DEPTH
//
// PORTS
// i_clk          in   1          system clock
// i_rst_n        in   1          synchronous reset, active low
// i_left         in   16         left sample, two's complement
// i_right        in   16         right sample, two's complement
// i_valid        in   1          producer has a pair on i_left/i_right
// o_ready        out  1          FIFO can accept; = ~o_full
// i_req          in   1          one-cycle pop request (I2S transmitter o_req)
// o_sample       out  32         {left[15:0], right[15:0]} to I2S i_sample
// o_level        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// o_full         out  1          o_level == DEPTH
// o_empty        out  1          o_level == 0
// o_running      out  1          state == RUN
// o_underrun     out  1          one-cycle pulse: i_req while RUN and empty
//
// BEHAVIOUR
// - Reset (i_rst_n low at i_clk edge): pointers/level 0, state PRIME,
//   o_sample 0, o_underrun 0, o_full 0, o_empty 1, o_ready 1, o_running 0.
// - Push: i_valid & o_ready at edge writes {i_left,i_right}; no push when full,
//   even if a pop occurs in the same cycle (o_ready is from registered level).
// - Pop (RUN only): i_req & ~o_empty -> o_sample <= head entry next cycle,
//   read pointer advances. Latency i_req -> o_sample valid: 1 cycle.
// - o_sample is registered, changes only on a cycle following i_req; held stable
//   between requests (quasi-static across the audio-clock crossing).
// - Simultaneous push+pop: level unchanged, both pointers advance.
// - Pointers wrap modulo DEPTH; level tracks occupancy independently.
// - State machine:
//   PRIME: i_req -> o_sample <= 0, no pop, no o_underrun.
//          o_level >= PRIME_LVL (registered level) -> RUN next cycle.
//   RUN:   i_req & ~empty -> pop as above.
//          i_req & empty -> o_sample <= 0, o_underrun = 1 for 1 cycle,
//          -> PRIME next cycle. A push in that same cycle is stored, never
//          bypassed to o_sample.
// - i_req wider than 1 cycle: each high cycle is a separate request.
// - Reset mid-operation discards all buffered data; next frame outputs 0.
//
// CONFIGURATION
// AUD_FIFO_UNDERRUN_CNT_EN defined: adds ports
//   i_cnt_clr       in  1   synchronous clear of counter (priority over incr.)
//   o_underrun_cnt  out 16  count of o_underrun pulses, saturates at 16'hFFFF,
//                           reset 0.
// Not defined: ports and counter absent; all other behaviour identical.
//
// TESTING
// 1 Reset, push 3 pairs, pulse i_req -> o_sample 0, o_running 0, o_underrun 0.
// 2 Push 4th pair (L=16'h1234,R=16'hABCD first) -> o_running 1; i_req ->
//   o_sample 32'h1234ABCD one cycle later, o_level 3.
// 3 Fill to 8 -> o_full 1, o_ready 0; i_valid held with i_req same cycle ->
//   level 7, pushed pair not stored.
// 4 RUN, drain to empty, i_req -> o_sample 0, o_underrun 1 cycle, o_running 0
//   next cycle; counter (if enabled) = 1; i_cnt_clr -> 0.
// 5 Push+pop same cycle at level 5 for 20 cycles -> level stays 5, data order
//   preserved through pointer wrap.
// 6 Assert i_rst_n low mid-stream at level 6 -> level 0, o_sample 0, PRIME.

Source files
------------

// File: rtl/aud_sample_fifo.sv
// ============================================================================
// Module   : aud_sample_fifo
// Purpose  : Stereo sample FIFO between the mixer and the I2S transmitter.
//            A PRIME/RUN state machine hides start-up fill and recovers
//            from underrun.
// Options  : AUD_FIFO_UNDERRUN_CNT_EN adds a saturating 16-bit underrun
//            counter with a synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aud_sample_fifo #(
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [15:0]              i_left,
  input  logic [15:0]              i_right,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_req,
  output logic [31:0]              o_sample,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_running,
  output logic                     o_underrun
`ifdef AUD_FIFO_UNDERRUN_CNT_EN
  ,
  input  logic                     i_cnt_clr,
  output logic [15:0]              o_underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [31:0]     sample;
  logic            underrun;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            underrun_evt;

  // Flags come straight from the registered level so o_ready never depends
  // on a same-cycle pop.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign push         = i_valid & ~full;
  assign pop          = i_req & (state == RUN) & ~empty;
  assign underrun_evt = i_req & (state == RUN) & empty;

  // Next-state logic: fill to the prime threshold, drop back on underrun.
  always_comb begin
    state_next = state;
    case (state)
      PRIME:   if (level >= LW'(PRIME_LVL)) state_next = RUN;
      RUN:     if (underrun_evt)            state_next = PRIME;
      default: state_next = PRIME;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= PRIME;
    else          state <= state_next;
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_left, i_right};
  end

  // Pointers wrap naturally at DEPTH; level tracks occupancy on its own.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output word is updated only on a request and held between requests.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sample   <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= underrun_evt;
      if (i_req) sample <= pop ? mem[rd_ptr] : 32'h0;
    end
  end

`ifdef AUD_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;

  // Saturating underrun counter; clear wins over increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                 underrun_cnt <= '0;
    else if (i_cnt_clr)                           underrun_cnt <= '0;
    else if (underrun_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
  end

  assign o_underrun_cnt = underrun_cnt;
`endif

  assign o_ready    = ~full;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_level    = level;
  assign o_sample   = sample;
  assign o_running  = (state == RUN);
  assign o_underrun = underrun;

endmodule

`default_nettype wire

// File: tb/tb_aud_sample_fifo.sv
// ============================================================================
// Module   : tb_aud_sample_fifo
// Purpose  : Scoreboard bench for aud_sample_fifo: a queue-based reference
//            model predicts each request's output word, a monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aud_sample_fifo;

  localparam int DEPTH     = 8;
  localparam int PRIME_LVL = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   left, right;
  logic          valid, req;
  logic          ready, full, empty, running, underrun;
  logic [31:0]   sample;
  logic [LW-1:0] level;
  logic          cnt_clr;
  logic [15:0]   underrun_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];        // buffered pairs, oldest first
  logic [31:0] exp_q[$];     // expected o_sample per issued request
  bit          m_run;
  bit          m_und;
  logic [31:0] m_sample;
  int          m_cnt;
  bit          req_d;

  aud_sample_fifo #(.DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_left     (left),
    .i_right    (right),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_req      (req),
    .o_sample   (sample),
    .o_level    (level),
    .o_full     (full),
    .o_empty    (empty),
    .o_running  (running),
    .o_underrun (underrun)
`ifdef AUD_FIFO_UNDERRUN_CNT_EN
    ,
    .i_cnt_clr      (cnt_clr),
    .o_underrun_cnt (underrun_cnt)
`endif
  );

`ifndef AUD_FIFO_UNDERRUN_CNT_EN
  assign underrun_cnt = 16'h0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each request is answered one edge later; pop the prediction.
  always @(posedge clk) req_d <= rst_n & req;

  always @(negedge clk) begin
    if (req_d) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sample_order: DUT word %h with no expected entry", sample);
      end else begin
        chk("sample", sample, exp_q.pop_front());
      end
    end
  end

  // One cycle: check current outputs against the model, drive inputs, then
  // advance the model to what the coming edge must produce.
  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r,
                      input bit q, input bit c);
    int sz;
    bit und;
    @(negedge clk);
    chk("level",    32'(level),    32'(mq.size()));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("ready",    32'(ready),    32'(mq.size() != DEPTH));
    chk("running",  32'(running),  32'(m_run));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("hold",     sample,        m_sample);
`ifdef AUD_FIFO_UNDERRUN_CNT_EN
    chk("ucnt",     32'(underrun_cnt), 32'(m_cnt));
`endif
    valid = v; left = l; right = r; req = q; cnt_clr = c;
    sz  = mq.size();
    und = 1'b0;
    if (q) begin
      if (!m_run)       m_sample = 32'h0;
      else if (sz > 0)  m_sample = mq.pop_front();
      else begin        m_sample = 32'h0; und = 1'b1; end
      exp_q.push_back(m_sample);
    end
    if (v && sz < DEPTH) mq.push_back({l, r});
    if (c)                      m_cnt = 0;
    else if (und && m_cnt < 65535) m_cnt++;
    if (!m_run && sz >= PRIME_LVL) m_run = 1'b1;
    else if (und)                  m_run = 1'b0;
    m_und = und;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 0; req = 0; cnt_clr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); exp_q.delete();
    m_run = 0; m_und = 0; m_sample = 32'h0; m_cnt = 0;
  endtask

  task automatic push_rand();
    step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; req = 0; cnt_clr = 0; left = 0; right = 0;
    do_reset();

    // Prime fill: three pairs, a request yields zero while priming
    step(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    push_rand(); push_rand();
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();

    // Fourth pair enters RUN; first pop returns the first pair
    push_rand(); idle(); idle();
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();
    chk("first_word", sample, 32'h1234ABCD);

    // Fill to full, then push blocked while popping
    while (mq.size() < DEPTH) push_rand();
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
    idle();

    // Drain to empty then underrun
    while (mq.size() > 0) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(); idle();
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    idle();

    // Steady push+pop at level 5 through pointer wrap
    while (mq.size() < 5) push_rand();
    idle(); idle();
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    idle();

    // Reset mid-stream at level 6
    while (mq.size() < 6) push_rand();
    do_reset();
    idle();

    // Randomized traffic with varying producer/consumer rates
    for (int ph = 0; ph < 6; ph++) begin
      int pv = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 40 : 25;
      int pr = (ph % 2 == 0) ? 30 : 55;
      for (int i = 0; i < 150; i++)
        step(($urandom % 100) < pv, 16'($urandom), 16'($urandom),
             ($urandom % 100) < pr, ($urandom % 100) < 3);
    end
    idle(); idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words never observed, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
